// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS digits, each held for REFRESH_DIV cycles,
// with frame-synchronous value loading, leading-zero blanking and selectable output polarity.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int DATA_WIDTH       = 4 * NUM_DIGITS,
  parameter int REFRESH_DIV      = 1024,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic [NUM_DIGITS-1:0] dp_mask_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] digit_sel_o,
  output logic                  frame_done_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] staging_q, staging_d;
  logic [DATA_WIDTH-1:0] display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  bnd_q, bnd_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fd_q, fd_d;

  logic                  cnt_wrap;
  logic                  boundary;
  logic [3:0]            nib;
  logic                  dp_cur;
  logic                  lz_cur;
  logic [NUM_DIGITS-1:0] sel_cur;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    staging_d = staging_q;
    display_d = display_q;
    pending_d = pending_q;
    bnd_d     = bnd_q;
    nib       = '0;
    dp_cur    = 1'b0;
    lz_cur    = 1'b0;
    sel_cur   = '0;
    cnt_wrap  = enable_i && (cnt_q == CNT_LAST);
    boundary  = cnt_wrap && (idx_q == IDX_LAST);

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib        = display_q[4*k +: 4];
        dp_cur     = dp_mask_i[k];
        sel_cur[k] = 1'b1;
        lz_cur     = (k > 0) && ((display_q >> (4*k)) == '0);
      end
    end

    // bnd_q remembers a crossed frame boundary until digit 0 is actually latched out
    if (enable_i) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
      bnd_d = 1'b0;
    end
    if (cnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    if (boundary) bnd_d = 1'b1;

    if (load_i) begin
      staging_d = value_i;
      if (boundary) begin
        display_d = value_i;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (boundary && pending_q) begin
      display_d = staging_q;
      pending_d = 1'b0;
    end

    seg_d = '0;
    dp_d  = 1'b0;
    sel_d = '0;
    fd_d  = enable_i && bnd_q;
    if (enable_i) begin
      seg_d = (blank_lz_i && lz_cur) ? 7'h00 : hex7(nib);
      dp_d  = dp_cur;
      sel_d = sel_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      bnd_q     <= 1'b0;
      seg_q     <= '0;
      dp_q      <= 1'b0;
      sel_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      display_q <= display_d;
      pending_q <= pending_d;
      bnd_q     <= bnd_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_o        = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp_o         = dp_q ^ SEG_ACTIVE_LOW;
  assign digit_sel_o  = sel_q ^ {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
  assign frame_done_o = fd_q;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed, multi-digit seven-segment driver. Generalises the single-digit, purely combinational hex decoder on the top-level wrapper to NUM_DIGITS scanned digits.
- Adds tear-free value loading, leading-zero blanking, per-digit decimal points and configurable output polarity.
- Sits between the CPU's memory-mapped count value and the uo_out/uio_out pads of the tt_um top level.

Parameters:
- NUM_DIGITS, 4: number of scanned digits (2..8).
- DATA_WIDTH, 4*NUM_DIGITS: width of value; nibble k drives digit k.
- REFRESH_DIV, 1024: clock cycles each digit stays selected (>=2).
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the output.
- DIGIT_ACTIVE_LOW, 0: 1 inverts digit_sel at the output.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: scan enable.
- value, input, DATA_WIDTH: hex value to display; digit 0 = value[3:0].
- load, input, 1: capture strobe for value.
- blank_lz, input, 1: leading-zero blanking enable.
- dp_mask, input, NUM_DIGITS: decimal-point enable per digit, sampled live.
- seg, output, 7: segments {g,f,e,d,c,b,a}.
- dp, output, 1: decimal point.
- digit_sel, output, NUM_DIGITS: one-hot digit enable.
- frame_done, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - dwell counter=0, digit index=0, staging=0, display=0, pending=0.
  - seg, dp and digit_sel inactive (all 0 before polarity inversion); frame_done=0.
- Dwell counter:
  - enable=1: increments 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and the index advances, wrapping NUM_DIGITS-1 -> 0.
  - enable=0: counter and index hold; seg, dp and digit_sel are forced inactive from the next edge.
  - Re-enabling resumes from the held counter and index.
- Outputs: all registered, one cycle after the internal index/counter state they reflect.
  - Each digit is active for exactly REFRESH_DIV consecutive cycles.
  - digit_sel is always one-hot (or all-inactive); it is never two-hot, including at transitions.
- Value loading (tear-free):
  - load=1 captures value into staging and sets pending.
  - The frame boundary is the cycle in which the counter wraps while index = NUM_DIGITS-1. At the boundary, if pending=1, display <= staging and pending is cleared.
  - load at the boundary cycle: value goes directly into both display and staging; pending=0.
  - Repeated loads within a frame: the last one wins.
- frame_done: registered pulse, high for exactly 1 cycle per frame, aligned with the first cycle digit 0 is shown after the boundary.
- Decode:
  - Hex encoding, active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - dp = dp_mask[index].
- Leading-zero blanking:
  - Applies when blank_lz=1 and digit k>0 has display nibbles k..NUM_DIGITS-1 all zero.
  - A blanked digit has seg=0 but dp still follows dp_mask, and digit_sel is still scanned.
  - Digit 0 is never blanked.
- Polarity: SEG_ACTIVE_LOW and DIGIT_ACTIVE_LOW invert after the output registers, so reset values become all-ones on those outputs.
- Reset mid-frame: all state returns to reset values immediately, and any pending load is discarded.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, polarities 0):
1. Reset, enable=1, load 0x12AF in first cycle -> after first boundary, digit_sel cycles 0001,0010,0100,1000 for 4 cycles each; seg=71,77,5B,06 respectively; frame_done pulses every 16 cycles.
2. Tear test: display=0x1234, load 0xFFFF mid-digit-1 -> remainder of frame still shows 4,3,2,1 patterns (66,4F,5B,06 on digits 0..3); next frame shows all 71.
3. blank_lz=1, value 0x0005 -> digit0 seg=6D; digits 1-3 seg=00 with digit_sel still scanning; value 0x0000 -> digit0 seg=3F.
4. enable=0 during digit 2 for 10 cycles -> seg/dp/digit_sel=0 next edge; on re-enable, digit 2 resumes for its remaining cycles; frame length extended by exactly 10.
5. load coincident with boundary, value 0x00C0 -> next digit 1 shows 39 with no extra frame delay; dp_mask=0100 -> dp=1 only while digit_sel=0100.
6. SEG_ACTIVE_LOW=1, DIGIT_ACTIVE_LOW=1; assert rst_n=0 mid-frame -> seg=7F, dp=1, digit_sel=1111 asynchronously; after release, scan restarts at digit 0 showing 0 (seg=40).
